// File: rtl/rca64_serial_ctrl_pkg.sv
// rca64_serial_ctrl_pkg: shared FSM state encoding and default slice geometry.
package rca64_serial_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int DEF_WORD_W = 16;
  localparam int DEF_NWORDS = 4;
endpackage

// File: rtl/rca64_serial_ctrl_rca_slice.sv
// rca_slice: combinational WORD_W-bit ripple adder slice with carry in/out.
module rca_slice #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

// File: rtl/rca64_serial_ctrl.sv
// rca64_serial_ctrl: wide adder computed one slice per cycle through a single shared slice adder.
module rca64_serial_ctrl
  import rca64_serial_ctrl_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int NWORDS = DEF_NWORDS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORD_W*NWORDS-1:0] A,
  input  logic [WORD_W*NWORDS-1:0] B,
  input  logic                     Cin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_W*NWORDS-1:0] S,
  output logic                     Cout,
  output logic                     busy
);
  localparam int W = WORD_W * NWORDS;
  localparam int IDX_W = NWORDS > 1 ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NWORDS - 1);
  state_e state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic c_q, c_d, cout_q, cout_d;
  logic [WORD_W-1:0] sl_a, sl_b, sl_s;
  logic sl_c;
  assign sl_a = a_q[int'(idx_q)*WORD_W +: WORD_W];
  assign sl_b = b_q[int'(idx_q)*WORD_W +: WORD_W];
  rca_slice #(.W(WORD_W)) u_slice (
    .a(sl_a), .b(sl_b), .cin(c_q), .s(sl_s), .cout(sl_c)
  );
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    s_d = s_q;
    idx_d = idx_q;
    c_d = c_q;
    cout_d = cout_q;
    if (state_q == IDLE && in_valid) begin
      a_d = A;
      b_d = B;
      c_d = Cin;
      idx_d = '0;
      s_d = '0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      s_d[int'(idx_q)*WORD_W +: WORD_W] = sl_s;
      c_d = sl_c;
      idx_d = idx_q == LAST ? '0 : idx_q + 1'b1;
      cout_d = idx_q == LAST ? sl_c : cout_q;
      state_d = idx_q == LAST ? DONE : RUN;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
      idx_q <= '0;
      c_q <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_d;
      idx_q <= idx_d;
      c_q <= c_d;
      cout_q <= cout_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy = state_q != IDLE;
  assign S = s_q;
  assign Cout = cout_q;
endmodule

// File: tb/tb_rca64_serial_ctrl.sv
// tb_rca64_serial_ctrl: scoreboard bench; acceptances push A+B+Cin, a monitor pops on each output handshake.
module tb_rca64_serial_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, Cin = 1'b0, out_valid, out_ready = 1'b1, Cout, busy;
  logic [63:0] A = '0, B = '0, S;
  typedef struct {logic [64:0] v; int acc;} exp_t;
  exp_t exp_q[$];
  int vectors = 0, miscompares = 0, cyc = 0, last_acc = -1;
  bit b2b = 1'b0, pv = 1'b0, pr = 1'b0;
  logic [64:0] prev_res = '0, last_res = '0;
  rca64_serial_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B), .Cin(Cin),
    .out_valid(out_valid), .out_ready(out_ready), .S(S), .Cout(Cout), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge rst_n) exp_q.delete();
  function automatic logic [63:0] rnd64();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 5))
      0: r = '1;
      1: r = '0;
      default: ;
    endcase
    return r;
  endfunction
  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask
  // Monitor: acceptance is predicted one half-cycle ahead, results checked on handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        e.v = {1'b0, A} + {1'b0, B} + 65'(Cin);
        e.acc = cyc + 1;
        if (b2b && last_acc >= 0) chk("b2b_gap", 65'(e.acc - last_acc), 65'd6);
        last_acc = e.acc;
        exp_q.push_back(e);
      end
      if (out_valid && pv && !pr) chk("hold_result", {Cout, S}, prev_res);
      if (out_valid && exp_q.size() == 0) chk("spurious_valid", 65'(out_valid), 65'd0);
      else if (out_valid && !pv) chk("latency", 65'(cyc - exp_q[0].acc), 65'd4);
      if (out_valid && out_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("result", {Cout, S}, e.v);
        last_res = {Cout, S};
      end
      pv = out_valid;
      pr = out_ready;
      prev_res = {Cout, S};
    end
  end
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic c);
    int n = 0;
    A = a;
    B = b;
    Cin = c;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 65'(in_ready), 65'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = rnd64();
    B = rnd64();
    Cin = 1'($urandom);
  endtask
  task automatic wait_empty(input int d);
    int n = 0;
    repeat (d) @(posedge clk);
    #1 out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 65'(exp_q.size()), 65'd0);
  endtask
  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 65'(in_ready), 65'd1);
    chk("rst_out_valid", 65'(out_valid), 65'd0);
    chk("rst_busy", 65'(busy), 65'd0);
    chk("rst_result", {Cout, S}, 65'd0);
    @(posedge clk);
    #1;
    send(64'd1, 64'd2, 1'b0);
    @(negedge clk);
    chk("run_busy", 65'(busy), 65'd1);
    chk("run_in_ready", 65'(in_ready), 65'd0);
    @(posedge clk);
    #1;
    wait_empty(0);
    chk("small_sum", last_res, 65'd3);
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
    wait_empty(0);
    chk("full_carry", last_res, {1'b1, 64'd0});
    send(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0);
    wait_empty(0);
    chk("slice_carry", last_res, {1'b0, 64'h0001_0000_0001_0000});
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    wait_empty(0);
    chk("all_ones", last_res, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
    // Stall the consumer and pester the input side while a result is held.
    out_ready = 1'b0;
    send(rnd64(), rnd64(), 1'($urandom));
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stall_valid", 65'(out_valid), 65'd1);
    repeat (10) begin
      @(posedge clk);
      #1;
      A = rnd64();
      B = rnd64();
      in_valid = 1'($urandom);
      @(negedge clk);
      chk("stall_in_ready", 65'(in_ready), 65'd0);
      chk("stall_out_valid", 65'(out_valid), 65'd1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("release_idle", {63'd0, in_ready, out_valid}, 65'b10);
    chk("release_drained", 65'(exp_q.size()), 65'd0);
    @(posedge clk);
    #1;
    A = rnd64();
    B = rnd64();
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("abort_valid", 65'(out_valid), 65'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", 65'(out_valid), 65'd0);
    chk("abort_S", 65'(S), 65'd0);
    chk("abort_in_ready", 65'(in_ready), 65'd1);
    @(posedge clk);
    #1;
    send(64'd5, 64'd7, 1'b0);
    wait_empty(0);
    chk("after_abort", last_res, 65'd12);
    repeat (20) begin
      out_ready = 1'($urandom);
      send(rnd64(), rnd64(), 1'($urandom));
      wait_empty($urandom_range(0, 7));
    end
    b2b = 1'b1;
    last_acc = -1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    repeat (40) begin
      A = rnd64();
      B = rnd64();
      Cin = 1'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_empty(0);
    b2b = 1'b0;
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/rca64_serial_ctrl.md
RCA64_SERIAL_CTRL -- requirements
Module: rca64_serial_ctrl

Interface
REQ-001 Parameter WORD_W, default 16, width of the shared adder slice in bits.
REQ-002 Parameter NWORDS, default 4, number of slices per operand; operand width is WORD_W*NWORDS.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  requester presents an operand set.
REQ-006 in_ready  output  1  block can accept an operand set this cycle.
REQ-007 A  input  WORD_W*NWORDS  operand A, sampled at acceptance.
REQ-008 B  input  WORD_W*NWORDS  operand B, sampled at acceptance.
REQ-009 Cin  input  1  carry-in, sampled at acceptance.
REQ-010 out_valid  output  1  S and Cout hold a completed result.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 S  output  WORD_W*NWORDS  registered sum.
REQ-013 Cout  output  1  registered final carry-out.
REQ-014 busy  output  1  high in RUN or DONE.

Function
REQ-015 The block SHALL compute {Cout,S} = A + B + Cin modulo 2^(WORD_W*NWORDS+1), one WORD_W slice per cycle, through a single shared slice adder.
REQ-016 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-017 In IDLE, in_ready SHALL be 1; on in_valid&&in_ready it SHALL latch A, B, carry register <= Cin, slice index <= 0, S <= 0, and go to RUN.
REQ-018 In RUN, each cycle the slice adder SHALL add A-slice[idx], B-slice[idx] and the carry register; the result SHALL be written to S-slice[idx], carry register <= slice carry, idx <= idx+1.
REQ-019 When the slice with idx = NWORDS-1 is written, the FSM SHALL go to DONE, Cout <= that slice's carry, and out_valid SHALL be 1 in the next cycle.
REQ-020 Latency SHALL be exactly NWORDS cycles from the accepting edge to the first cycle out_valid is high (4 at default).
REQ-021 In DONE, S, Cout and out_valid SHALL hold stable until out_valid&&out_ready; on that edge the FSM SHALL go to IDLE and out_valid SHALL fall.
REQ-022 in_ready SHALL be 0 in RUN and DONE; in_valid in those states SHALL be ignored and no operand latched.
REQ-023 There SHALL be no same-cycle bypass from DONE to RUN; a new acceptance needs one IDLE cycle (throughput one result per NWORDS+2 cycles with out_ready held high).
REQ-024 Changes on A, B or Cin after acceptance SHALL NOT affect the result in progress.
REQ-025 Slice index SHALL be ceil(log2(NWORDS)) bits wide, minimum 1, and SHALL never exceed NWORDS-1.
REQ-026 Carry propagation SHALL be exact across all slices, including all-ones operands with Cin=1.

Reset
REQ-027 On rst_n low, asynchronously: state <= IDLE, S <= 0, Cout <= 0, out_valid <= 0, carry register <= 0, idx <= 0, latched operands <= 0.
REQ-028 Reset asserted during RUN or DONE SHALL abort the operation with no partial result ever flagged valid.
REQ-029 After rst_n rises, in_ready SHALL be 1 in the first cycle.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (IDLE, RUN, DONE) and the default WORD_W and NWORDS constants.
REQ-031 The slice adder SHALL be one combinational sub-module, rca_slice, ports a, b, cin, s, cout of width WORD_W.
REQ-032 The controller SHALL instantiate exactly one rca_slice; slice selection SHALL be by index multiplexing.

Verification
REQ-033 A=1, B=2, Cin=0, out_ready=1 -> out_valid high exactly 4 cycles after acceptance, S=3, Cout=0.
REQ-034 A=64'hFFFF_FFFF_FFFF_FFFF, B=0, Cin=1 -> S=0, Cout=1, proving carry across all four slices.
REQ-035 A=64'h0000_FFFF_0000_FFFF, B=64'h0000_0001_0000_0001, Cin=0 -> S=64'h0001_0000_0001_0000, Cout=0.
REQ-036 Hold out_ready=0 for 10 cycles after out_valid, toggle A, B and in_valid -> S, Cout stable, in_ready=0, no new acceptance; release out_ready -> IDLE next cycle.
REQ-037 Assert rst_n low 2 cycles into RUN -> out_valid=0, S=0, in_ready=1 after release; a following 5+7 transaction returns S=12.
REQ-038 Back-to-back transactions with in_valid and out_ready held high -> one acceptance every 6 cycles, each result correct against a reference model.
